vpu_seq: RTL and testbench
==========================

Name: vpu_seq

Overview:
- Multi-beat sequencer for the 8-lane x 16-bit vector unit (VPU).
- Accepts one vector command per handshake and decodes its opcode into the VPU one-hot select lines.
- Streams 1..4 beats of 128-bit operands from a synchronous-read vector register file through the combinational VPU, writes vd back, collects per-beat compare bits into a 32-bit scalar result, then returns a response.

Parameters:
- RF_AW, 5, vector register file address width.
- MAX_BEATS, 4, maximum beats per command; fixed by 32-bit mask / 8 lanes per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  sequencer can accept a command.
- req_op  in  5  opcode: 0 add, 1 sub, 2 mul, 3 itf, 4 fti, 5 max, 6 min, 7 and, 8 or, 9 xor, 10 sra, 11 srl, 12 sll, 13 cge, 14 clt, 15 ceq, 16 cnq.
- req_if  in  1  1 = float datapath, 0 = integer.
- req_vlen  in  3  beat count, legal 1..4.
- req_vs1, req_vs2, req_vd  in  RF_AW  base register addresses.
- req_masken  in  1  enable lane masking.
- req_mask  in  32  lane mask; bits 8k+7..8k apply to beat k.
- req_scalar  in  32  scalar operand; drives VPU fs and rs.
- resp_valid  out  1  command complete.
- resp_ready  in  1  response accepted.
- resp_err  out  1  illegal opcode or vlen.
- resp_data  out  32  compare result; 0 for non-compare ops.
- rf_raddr1, rf_raddr2  out  RF_AW  read addresses; data returns the next cycle.
- rf_rdata1, rf_rdata2  in  128  read data.
- rf_we  out  1  write enable.
- rf_waddr  out  RF_AW  write address.
- rf_wdata  out  128  write data (VPU vd).
- vpu_vec_en, vpu_ifsel  out  1 each  VPU controls.
- vpu_sel  out  17  one-hot selects, same bit order as the opcodes.
- vpu_vs1, vpu_vs2  out  128 each  VPU operands.
- vpu_fs, vpu_rs  out  32 each  VPU scalars.
- vpu_mask  out  32  VPU mask_in.
- vpu_vd  in  128  VPU vector result.
- vpu_rd  in  32  VPU scalar result; compare bits in [7:0].

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - All outputs are 0 except req_ready = 1.
  - Beat counters and result accumulator are cleared.
  - rst asserted mid-command aborts it; no further rf_we is issued after the reset cycle.
- States are IDLE, RUN, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, all request fields are latched.
  - If req_op > 16 or req_vlen is 0 or > 4, go to RESP with resp_err = 1. No reads or writes occur.
  - Otherwise go to RUN with rd_cnt = 0, ex_cnt = 0, accumulator = 0.
- RUN (pipelined, one beat per cycle):
  - While rd_cnt < vlen: rf_raddr1 = vs1 + rd_cnt, rf_raddr2 = vs2 + rd_cnt, then rd_cnt increments. Address addition wraps modulo 2^RF_AW.
  - From the second RUN cycle onward, beat ex_cnt executes: rf_rdata1/2 drive vpu_vs1/vpu_vs2 combinationally.
  - Non-compare op: rf_we = 1, rf_waddr = vd + ex_cnt, rf_wdata = vpu_vd.
  - Compare op (13..16): rf_we = 0; accumulator[8*ex_cnt +: 8] <= vpu_rd[7:0].
  - After the beat with ex_cnt = vlen-1, go to RESP.
  - RUN lasts vlen+1 cycles; the first RUN cycle only reads.
- Decode while in RUN:
  - vpu_sel is the one-hot of the latched op; vpu_vec_en = 1; vpu_ifsel = latched req_if.
  - vpu_fs = vpu_rs = latched scalar.
  - vpu_mask = masken ? {24'h0, mask[8*ex_cnt +: 8]} : 32'h0000_00FF.
  - All vpu_* outputs are 0 outside RUN.
- RESP:
  - resp_valid = 1; resp_data = accumulator for compare ops, else 0; resp_err as latched.
  - On resp_ready, go to IDLE. Back-to-back commands therefore need at least one IDLE cycle.
- Masked lanes are still written; the VPU passes vs1 through on those lanes.
- The sequencer performs no overlap check. Results are undefined if the vd range partially overlaps the vs1 or vs2 range. Identical bases (vd == vs1) are legal, because each read precedes its write.
- The register file returns old data on read-during-write to the same address.

Test Plan:
- add, vlen = 2, vs1 = 4, vs2 = 8, vd = 12, masken = 0 -> reads at cycles 1 and 2; rf_we at cycles 2 and 3 with waddr 12 then 13; vpu_mask = 0xFF; resp_valid at cycle 4 with resp_data = 0.
- ceq, vlen = 4, integer datapath, vpu_rd[7:0] stubbed to 0x11, 0x22, 0x33, 0x44 per beat -> rf_we never asserted; resp_data = 0x44332211.
- mul, vlen = 3, masken = 1, mask = 0x00F0_0F01 -> vpu_mask sequence 0x01, 0x0F, 0xF0.
- req_op = 20, or vlen = 0, or vlen = 5 -> no reads or writes; next cycle resp_valid = 1, resp_err = 1.
- RF_AW = 5, vs1 = 31, vlen = 2 -> rf_raddr1 sequence 31, 0; resp_ready held low for 5 cycles -> resp_valid and resp_data stay stable, req_ready = 0.
- rst asserted during the second execute beat of a vlen = 4 add -> rf_we = 0 from the next cycle; req_ready = 1, resp_valid = 0.

Source files
------------

// File: rtl/vpu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vpu_seq_if
// Brief    : Command request / response handshake bundle for the VPU sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface vpu_seq_if #(
    parameter int RF_AW = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic              req_if;
    logic [2:0]        req_vlen;
    logic [RF_AW-1:0]  req_vs1;
    logic [RF_AW-1:0]  req_vs2;
    logic [RF_AW-1:0]  req_vd;
    logic              req_masken;
    logic [31:0]       req_mask;
    logic [31:0]       req_scalar;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_err;
    logic [31:0]       resp_data;

    modport master (
        output req_valid, req_op, req_if, req_vlen, req_vs1, req_vs2, req_vd,
               req_masken, req_mask, req_scalar, resp_ready,
        input  req_ready, resp_valid, resp_err, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_if, req_vlen, req_vs1, req_vs2, req_vd,
               req_masken, req_mask, req_scalar, resp_ready,
        output req_ready, resp_valid, resp_err, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/vpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : vpu_seq
// Brief    : Multi-beat sequencer streaming register-file operands through the VPU.
// Revision : 1.0  initial release
// ============================================================================
module vpu_seq #(
    parameter int RF_AW     = 5,
    parameter int MAX_BEATS = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    vpu_seq_if.slave               bus,
    output logic [RF_AW-1:0]       rf_raddr1,
    output logic [RF_AW-1:0]       rf_raddr2,
    input  wire logic [127:0]      rf_rdata1,
    input  wire logic [127:0]      rf_rdata2,
    output logic                   rf_we,
    output logic [RF_AW-1:0]       rf_waddr,
    output logic [127:0]           rf_wdata,
    output logic                   vpu_vec_en,
    output logic                   vpu_ifsel,
    output logic [16:0]            vpu_sel,
    output logic [127:0]           vpu_vs1,
    output logic [127:0]           vpu_vs2,
    output logic [31:0]            vpu_fs,
    output logic [31:0]            vpu_rs,
    output logic [31:0]            vpu_mask,
    input  wire logic [127:0]      vpu_vd,
    input  wire logic [31:0]       vpu_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [4:0] c_OP_LAST = 5'd16;
    localparam logic [4:0] c_OP_CGE  = 5'd13;

    state_t            r_state;
    logic [2:0]        r_rd_cnt;
    logic [1:0]        r_ex_cnt;
    logic [31:0]       r_acc;
    logic [4:0]        r_op;
    logic              r_if;
    logic [2:0]        r_vlen;
    logic [RF_AW-1:0]  r_vs1;
    logic [RF_AW-1:0]  r_vs2;
    logic [RF_AW-1:0]  r_vd;
    logic              r_masken;
    logic [31:0]       r_mask;
    logic [31:0]       r_scalar;
    logic              r_err;

    logic w_illegal;
    logic w_run;
    logic w_rd;
    logic w_exec;
    logic w_cmp;
    logic w_last;
    logic w_unused_rd;

    assign w_illegal = (bus.req_op > c_OP_LAST) || (bus.req_vlen == 3'd0) ||
                       (bus.req_vlen > 3'(MAX_BEATS));
    assign w_run     = (r_state == S_RUN);
    assign w_rd      = w_run && (r_rd_cnt < r_vlen);
    // rd_cnt only stays at zero during the read-only first RUN cycle
    assign w_exec    = w_run && (r_rd_cnt != 3'd0);
    assign w_cmp     = (r_op >= c_OP_CGE) && (r_op <= c_OP_LAST);
    assign w_last    = ({1'b0, r_ex_cnt} == (r_vlen - 3'd1));
    assign w_unused_rd = ^vpu_rd[31:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= 3'd0;
            r_ex_cnt <= 2'd0;
            r_acc    <= 32'd0;
            r_op     <= 5'd0;
            r_if     <= 1'b0;
            r_vlen   <= 3'd0;
            r_vs1    <= '0;
            r_vs2    <= '0;
            r_vd     <= '0;
            r_masken <= 1'b0;
            r_mask   <= 32'd0;
            r_scalar <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op     <= bus.req_op;
                        r_if     <= bus.req_if;
                        r_vlen   <= bus.req_vlen;
                        r_vs1    <= bus.req_vs1;
                        r_vs2    <= bus.req_vs2;
                        r_vd     <= bus.req_vd;
                        r_masken <= bus.req_masken;
                        r_mask   <= bus.req_mask;
                        r_scalar <= bus.req_scalar;
                        r_rd_cnt <= 3'd0;
                        r_ex_cnt <= 2'd0;
                        r_acc    <= 32'd0;
                        r_err    <= w_illegal;
                        r_state  <= w_illegal ? S_RESP : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_rd) begin
                        r_rd_cnt <= r_rd_cnt + 3'd1;
                    end
                    if (w_exec) begin
                        if (w_cmp) begin
                            r_acc[8*r_ex_cnt +: 8] <= vpu_rd[7:0];
                        end
                        r_ex_cnt <= r_ex_cnt + 2'd1;
                        if (w_last) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (r_state == S_IDLE);
        bus.resp_valid = (r_state == S_RESP);
        bus.resp_err   = (r_state == S_RESP) && r_err;
        bus.resp_data  = ((r_state == S_RESP) && w_cmp) ? r_acc : 32'd0;

        rf_raddr1 = w_rd ? (r_vs1 + RF_AW'(r_rd_cnt)) : '0;
        rf_raddr2 = w_rd ? (r_vs2 + RF_AW'(r_rd_cnt)) : '0;
        rf_we     = w_exec && !w_cmp;
        rf_waddr  = rf_we ? (r_vd + RF_AW'(r_ex_cnt)) : '0;
        rf_wdata  = rf_we ? vpu_vd : 128'd0;

        vpu_vec_en = w_run;
        vpu_ifsel  = w_run && r_if;
        vpu_sel    = w_run ? (17'd1 << r_op) : 17'd0;
        vpu_vs1    = w_run ? rf_rdata1 : 128'd0;
        vpu_vs2    = w_run ? rf_rdata2 : 128'd0;
        vpu_fs     = w_run ? r_scalar : 32'd0;
        vpu_rs     = w_run ? r_scalar : 32'd0;
        vpu_mask   = 32'd0;
        if (w_run) begin
            vpu_mask = r_masken ? {24'h0, r_mask[8*r_ex_cnt +: 8]} : 32'h0000_00FF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_seq
// Brief    : Directed self-checking bench for vpu_seq with RF and VPU stubs.
// Revision : 1.0  initial release
// ============================================================================
module tb_vpu_seq;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rf_raddr1, rf_raddr2, rf_waddr;
    logic [127:0]  rf_rdata1, rf_rdata2, rf_wdata;
    logic          rf_we;
    logic          vpu_vec_en, vpu_ifsel;
    logic [16:0]   vpu_sel;
    logic [127:0]  vpu_vs1, vpu_vs2, vpu_vd;
    logic [31:0]   vpu_fs, vpu_rs, vpu_mask, vpu_rd;
    logic [127:0]  mem [32];
    int            n_checks = 0;
    int            n_errors = 0;

    vpu_seq_if #(.RF_AW(5)) bus ();

    vpu_seq #(.RF_AW(5), .MAX_BEATS(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .vpu_vec_en(vpu_vec_en), .vpu_ifsel(vpu_ifsel), .vpu_sel(vpu_sel),
        .vpu_vs1(vpu_vs1), .vpu_vs2(vpu_vs2), .vpu_fs(vpu_fs), .vpu_rs(vpu_rs),
        .vpu_mask(vpu_mask), .vpu_vd(vpu_vd), .vpu_rd(vpu_rd)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file, old data on read-during-write
    always @(posedge clk) begin
        rf_rdata1 <= mem[rf_raddr1];
        rf_rdata2 <= mem[rf_raddr2];
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    // VPU stub: vector add, compare bits taken from the low byte of vs1
    assign vpu_vd = vpu_vs1 + vpu_vs2;
    assign vpu_rd = {24'h0, vpu_vs1[7:0]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] op, input logic [2:0] vlen,
                          input logic [4:0] vs1, input logic [4:0] vs2,
                          input logic [4:0] vd, input logic masken,
                          input logic [31:0] mask);
        bus.req_op     = op;
        bus.req_if     = 1'b0;
        bus.req_vlen   = vlen;
        bus.req_vs1    = vs1;
        bus.req_vs2    = vs2;
        bus.req_vd     = vd;
        bus.req_masken = masken;
        bus.req_mask   = mask;
        bus.req_scalar = 32'h1234_5678;
        bus.req_valid  = 1'b1;
        step();
        bus.req_valid  = 1'b0;
    endtask

    task automatic release_resp();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, rf_we, vpu_vec_en} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, rf_we, vpu_vec_en});
        end
        n_checks++;
        if ({vpu_sel, vpu_mask, bus.resp_data, rf_raddr1} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: sel=%h mask=%h data=%h raddr1=%h expected all 0",
                     vpu_sel, vpu_mask, bus.resp_data, rf_raddr1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        accept(5'd0, 3'd2, 5'd4, 5'd8, 5'd12, 1'b0, 32'h0);
        // cycle 1: first read only
        n_checks++;
        if ({rf_raddr1, rf_raddr2, rf_we, vpu_vec_en, vpu_sel} !== {5'd4, 5'd8, 1'b0, 1'b1, 17'h1}) begin
            n_errors++;
            $display("FAIL add_c1: ra1=%0d ra2=%0d we=%b en=%b sel=%h expected 4 8 0 1 00001",
                     rf_raddr1, rf_raddr2, rf_we, vpu_vec_en, vpu_sel);
        end
        step();
        n_checks++;
        if ({rf_raddr1, rf_raddr2, rf_we, rf_waddr, vpu_mask} !== {5'd5, 5'd9, 1'b1, 5'd12, 32'hFF} ||
            rf_wdata !== 128'h11 || vpu_fs !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL add_c2: ra1=%0d ra2=%0d we=%b wa=%0d mask=%h wd=%h fs=%h expected 5 9 1 12 ff 11 12345678",
                     rf_raddr1, rf_raddr2, rf_we, rf_waddr, vpu_mask, rf_wdata, vpu_fs);
        end
        step();
        n_checks++;
        if ({rf_we, rf_waddr, bus.resp_valid} !== {1'b1, 5'd13, 1'b0} || rf_wdata !== 128'h22) begin
            n_errors++;
            $display("FAIL add_c3: we=%b wa=%0d rv=%b wd=%h expected 1 13 0 22",
                     rf_we, rf_waddr, bus.resp_valid, rf_wdata);
        end
        step();
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, rf_we, bus.req_ready} !== 4'b1000 || bus.resp_data !== 32'd0) begin
            n_errors++;
            $display("FAIL add_resp: rv=%b err=%b we=%b rr=%b data=%h expected 1 0 0 0 0",
                     bus.resp_valid, bus.resp_err, rf_we, bus.req_ready, bus.resp_data);
        end
        release_resp();
        n_checks++;
        if (bus.req_ready !== 1'b1 || mem[12] !== 128'h11 || mem[13] !== 128'h22) begin
            n_errors++;
            $display("FAIL add_wb: rr=%b m12=%h m13=%h expected 1 11 22",
                     bus.req_ready, mem[12], mem[13]);
        end
    endtask

    task automatic test_compare();
        accept(5'd15, 3'd4, 5'd16, 5'd20, 5'd24, 1'b0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (rf_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL ceq_run c%0d: we=%b rv=%b expected 0 0", c, rf_we, bus.resp_valid);
            end
            step();
        end
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h4433_2211 || mem[24] !== 128'h0) begin
            n_errors++;
            $display("FAIL ceq_resp: rv=%b data=%h m24=%h expected 1 44332211 0",
                     bus.resp_valid, bus.resp_data, mem[24]);
        end
        release_resp();
    endtask

    task automatic test_mask();
        logic [31:0] exp_mask [3];
        exp_mask[0] = 32'h01;
        exp_mask[1] = 32'h0F;
        exp_mask[2] = 32'hF0;
        accept(5'd2, 3'd3, 5'd4, 5'd8, 5'd28, 1'b1, 32'h00F0_0F01);
        step();
        for (int b = 0; b < 3; b++) begin
            n_checks++;
            if (vpu_mask !== exp_mask[b] || vpu_sel !== 17'h4) begin
                n_errors++;
                $display("FAIL mul_mask beat%0d: mask=%h sel=%h expected %h 00004",
                         b, vpu_mask, vpu_sel, exp_mask[b]);
            end
            step();
        end
        n_checks++;
        if (bus.resp_valid !== 1'b1 || vpu_mask !== 32'h0) begin
            n_errors++;
            $display("FAIL mul_resp: rv=%b mask=%h expected 1 0", bus.resp_valid, vpu_mask);
        end
        release_resp();
    endtask

    task automatic test_illegal();
        logic [4:0] ops [3];
        logic [2:0] lens [3];
        ops[0] = 5'd20; lens[0] = 3'd2;
        ops[1] = 5'd0;  lens[1] = 3'd0;
        ops[2] = 5'd0;  lens[2] = 3'd5;
        for (int k = 0; k < 3; k++) begin
            accept(ops[k], lens[k], 5'd4, 5'd8, 5'd12, 1'b0, 32'h0);
            n_checks++;
            if ({bus.resp_valid, bus.resp_err, rf_we, vpu_vec_en, rf_raddr1} !== {4'b1100, 5'd0} ||
                bus.resp_data !== 32'd0) begin
                n_errors++;
                $display("FAIL illegal case%0d: rv=%b err=%b we=%b en=%b ra1=%0d data=%h expected 1 1 0 0 0 0",
                         k, bus.resp_valid, bus.resp_err, rf_we, vpu_vec_en, rf_raddr1, bus.resp_data);
            end
            release_resp();
        end
    endtask

    task automatic test_wrap_stall();
        accept(5'd14, 3'd2, 5'd31, 5'd0, 5'd2, 1'b0, 32'h0);
        n_checks++;
        if (rf_raddr1 !== 5'd31) begin
            n_errors++;
            $display("FAIL wrap_ra1_c1: got %0d expected 31", rf_raddr1);
        end
        step();
        n_checks++;
        if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd1) begin
            n_errors++;
            $display("FAIL wrap_ra_c2: ra1=%0d ra2=%0d expected 0 1", rf_raddr1, rf_raddr2);
        end
        step();
        step();
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if ({bus.resp_valid, bus.req_ready} !== 2'b10 || bus.resp_data !== 32'h0000_A55A) begin
                n_errors++;
                $display("FAIL stall%0d: rv=%b rr=%b data=%h expected 1 0 0000a55a",
                         s, bus.resp_valid, bus.req_ready, bus.resp_data);
            end
            step();
        end
        release_resp();
    endtask

    task automatic test_reset_mid();
        mem[14] = 128'hDEAD;
        accept(5'd0, 3'd4, 5'd4, 5'd8, 5'd12, 1'b0, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({rf_we, bus.req_ready, bus.resp_valid, vpu_vec_en} !== 4'b0100) begin
                n_errors++;
                $display("FAIL rst_mid c%0d: we=%b rr=%b rv=%b en=%b expected 0 1 0 0",
                         c, rf_we, bus.req_ready, bus.resp_valid, vpu_vec_en);
            end
            step();
        end
        n_checks++;
        if (mem[14] !== 128'hDEAD) begin
            n_errors++;
            $display("FAIL rst_mid_mem: m14=%h expected dead", mem[14]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 128'h0;
        mem[4]  = 128'h1;  mem[5]  = 128'h2;
        mem[8]  = 128'h10; mem[9]  = 128'h20;
        mem[16] = 128'h11; mem[17] = 128'h22; mem[18] = 128'h33; mem[19] = 128'h44;
        mem[31] = 128'h5A; mem[0]  = 128'hA5;
        bus.req_valid  = 1'b0;
        bus.req_op     = 5'd0;
        bus.req_if     = 1'b0;
        bus.req_vlen   = 3'd0;
        bus.req_vs1    = 5'd0;
        bus.req_vs2    = 5'd0;
        bus.req_vd     = 5'd0;
        bus.req_masken = 1'b0;
        bus.req_mask   = 32'd0;
        bus.req_scalar = 32'd0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_add();
        test_compare();
        test_mask();
        test_illegal();
        test_wrap_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
